spram_fifo_sched: RTL and testbench
===================================

Name: spram_fifo_sched

Overview:
Access scheduler that runs a FIFO on one single-port RAM: one access (read or write) per cycle. Accepted writes enter a small staging buffer. Each cycle the block arbitrates between draining that buffer into RAM and serving a read request. It owns the RAM pointers, occupancy and flags, and sits between producer/consumer logic and a 1-cycle-latency SPRAM macro.

Parameters:
DATA_WIDTH, 8, data word width
FIFO_DEPTH, 32, RAM entries; must be a power of 2
ADDR_WIDTH, $clog2(FIFO_DEPTH), RAM address width
WBUF_DEPTH, 2, write staging buffer entries (>=1)
MAX_RD_STREAK, 4, consecutive read grants allowed while a write is pending

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
wen  in  1  write request
wdata  in  DATA_WIDTH  write data
full  out  1  write cannot be accepted
ren  in  1  read request (level; held until rack)
rack  out  1  read granted this cycle
rdata  out  DATA_WIDTH  read data, valid with rvalid
rvalid  out  1  rdata valid
empty  out  1  RAM holds no committed data
count  out  ADDR_WIDTH+1  committed RAM occupancy
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write (1) / read (0)
mem_addr  out  ADDR_WIDTH  RAM address
mem_wdata  out  DATA_WIDTH  RAM write data
mem_rdata  in  DATA_WIDTH  RAM read data, 1 cycle after read access

Behaviour:
Interface: one clock; reset is asynchronous and active-high.
- Reset values: full=0, empty=1, count=0, rack=0, rvalid=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. Pointers, staging buffer and streak counter are cleared.
- Write accept: wen && !full. Word is pushed into staging buffer, never bypassed to RAM the same cycle.
- full = (wbuf_cnt==WBUF_DEPTH) || (count+wbuf_cnt >= FIFO_DEPTH). Computed from registered state only; a same-cycle drain gives no credit.
- Candidates each cycle: R = ren && !empty; W = wbuf_cnt>0.
- Grant rule:
  - R only -> read. W only -> write. Neither -> idle.
  - R and W -> write if wbuf_cnt==WBUF_DEPTH or rd_streak==MAX_RD_STREAK; else read.
- rd_streak: increments on a read grant while W is true. Clears on any write grant, or when W is false. Saturates at MAX_RD_STREAK.
- Write grant:
  - mem_en=1, mem_we=1, mem_addr=waddr, mem_wdata=buffer head.
  - Pop head; waddr+1 (wraps mod FIFO_DEPTH); count+1 at the clock edge.
- Read grant:
  - mem_en=1, mem_we=0, mem_addr=raddr, rack=1.
  - raddr+1 (wraps); count-1 at the clock edge.
- Idle: mem_en=0, mem_we=0; mem_addr and mem_wdata driven 0.
- rack is combinational from registered state plus ren.
- rvalid: registered copy of rack, so rvalid is high exactly 1 cycle after rack.
- rdata = mem_rdata when rvalid, else 0.
- Write-to-read latency: a word accepted in cycle t is committed at earliest t+1 and readable (rack) at earliest t+2.
- Simultaneous push to and pop from the staging buffer in the same cycle is legal; wbuf_cnt is unchanged.
- count never exceeds FIFO_DEPTH; at FIFO_DEPTH, waddr==raddr with empty=0.
- Reset mid-operation: all buffered and RAM contents are discarded. An rvalid due in the next cycle is suppressed.
- ren while empty: no rack, no RAM access, ren stays pending.

Test Plan:
1. After reset, wen=1 wdata=0xA5 for 1 cycle -> next cycle mem_we=1, mem_addr=0, mem_wdata=0xA5; count goes 0->1, empty falls. Then ren=1 -> rack=1, mem_addr=0; next cycle rvalid=1, rdata=0xA5.
2. Continuous wen with ren=0, 32 words -> full rises once count+wbuf_cnt=32; count ends at 32 with waddr wrapped to 0; a further wen is ignored.
3. RAM holding 10 words, ren held high, single write accepted -> 4 consecutive rack grants, then 1 write grant, then reads resume. count ends at 10-5+1=6.
4. ren held high, wen pulsed every cycle with WBUF_DEPTH=2 -> write granted whenever wbuf_cnt==2; full asserts in exactly those cycles; no word lost or reordered; rdata matches a scoreboard.
5. Fill to 32, read 32, write 5 -> raddr/waddr wrap; readback data in order; empty=1 after the last rvalid.
6. Assert rst in the same cycle as a rack -> rvalid stays 0 the next cycle; count=0, empty=1, full=0 immediately.

Source files
------------

// File: rtl/spram_fifo_sched.sv
// spram_fifo_sched: FIFO controller for a single-port RAM with 1-cycle read
// latency. Writes are staged in a small buffer, and the RAM port is
// arbitrated each cycle between draining that buffer and serving a read.
// A bounded read streak keeps a steady read stream from starving writes.
module spram_fifo_sched #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 32,
  parameter int ADDR_WIDTH    = $clog2(FIFO_DEPTH),
  parameter int WBUF_DEPTH    = 2,
  parameter int MAX_RD_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  input  logic                  ren,
  output logic                  rack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int WC_W = $clog2(WBUF_DEPTH + 1);
  localparam int SK_W = (MAX_RD_STREAK > 0) ? $clog2(MAX_RD_STREAK + 1) : 1;

  localparam logic [WC_W-1:0]     WB_FULL = WC_W'(WBUF_DEPTH);
  localparam logic [SK_W-1:0]     SK_MAX  = SK_W'(MAX_RD_STREAK);
  localparam logic [ADDR_WIDTH+1:0] DEPTH_C = (ADDR_WIDTH+2)'(FIFO_DEPTH);

  // Control state
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [WC_W-1:0]       wbuf_cnt_q, wbuf_cnt_d;
  logic [SK_W-1:0]       streak_q, streak_d;
  logic                  rvalid_q;

  // Staging buffer storage; entry 0 is always the oldest word
  logic [DATA_WIDTH-1:0] wbuf_q [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] wbuf_d [WBUF_DEPTH];

  logic                  cand_r, cand_w;
  logic                  grant_r, grant_w;
  logic                  push, pop;
  logic [WC_W-1:0]       wr_idx;
  logic [ADDR_WIDTH+1:0] occ;

  // Flags derived purely from registered state (a same-cycle drain earns no credit)
  always_comb begin
    occ   = {1'b0, count_q} + (ADDR_WIDTH+2)'(wbuf_cnt_q);
    empty = (count_q == '0);
    full  = (wbuf_cnt_q == WB_FULL) || (occ >= DEPTH_C);
    count = count_q;
  end

  // Port arbitration: reads win unless the buffer is full or the read streak is spent
  always_comb begin
    cand_r  = ren && !empty;
    cand_w  = (wbuf_cnt_q != '0);
    grant_w = cand_w && (!cand_r || (wbuf_cnt_q == WB_FULL) || (streak_q == SK_MAX));
    grant_r = cand_r && !grant_w;
    push    = wen && !full;
    pop     = grant_w;
  end

  // RAM port drive; address and write data are held at zero when idle
  always_comb begin
    mem_en    = grant_w || grant_r;
    mem_we    = grant_w;
    mem_addr  = '0;
    mem_wdata = '0;
    rack      = grant_r;
    if (grant_w) begin
      mem_addr  = waddr_q;
      mem_wdata = wbuf_q[0];
    end else if (grant_r) begin
      mem_addr  = raddr_q;
    end
    rvalid = rvalid_q;
    rdata  = rvalid_q ? mem_rdata : '0;
  end

  // Next-state for pointers, occupancy, staging count and read streak
  always_comb begin
    waddr_d    = waddr_q;
    raddr_d    = raddr_q;
    count_d    = count_q;
    wbuf_cnt_d = wbuf_cnt_q;
    streak_d   = streak_q;
    if (grant_w) begin
      waddr_d = waddr_q + ADDR_WIDTH'(1);
      count_d = count_q + (ADDR_WIDTH+1)'(1);
    end
    if (grant_r) begin
      raddr_d = raddr_q + ADDR_WIDTH'(1);
      count_d = count_q - (ADDR_WIDTH+1)'(1);
    end
    case ({push, pop})
      2'b10:   wbuf_cnt_d = wbuf_cnt_q + WC_W'(1);
      2'b01:   wbuf_cnt_d = wbuf_cnt_q - WC_W'(1);
      default: wbuf_cnt_d = wbuf_cnt_q;
    endcase
    // The streak only means something while a write is waiting
    if (grant_w || !cand_w) begin
      streak_d = '0;
    end else if (grant_r && (streak_q != SK_MAX)) begin
      streak_d = streak_q + SK_W'(1);
    end
  end

  // Staging buffer next contents: shift on pop, append behind the survivors on push
  always_comb begin
    wr_idx = wbuf_cnt_q - (pop ? WC_W'(1) : WC_W'(0));
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      wbuf_d[i] = wbuf_q[i];
      if (pop) begin
        wbuf_d[i] = wbuf_q[(i + 1 < WBUF_DEPTH) ? i + 1 : i];
      end
      if (push && (wr_idx == WC_W'(i))) begin
        wbuf_d[i] = wdata;
      end
    end
  end

  // Control registers; reset discards everything and kills any in-flight rvalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      waddr_q    <= '0;
      raddr_q    <= '0;
      wbuf_cnt_q <= '0;
      streak_q   <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      count_q    <= count_d;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      wbuf_cnt_q <= wbuf_cnt_d;
      streak_q   <= streak_d;
      rvalid_q   <= grant_r;
    end
  end

  // Staging data registers; validity is tracked solely by wbuf_cnt_q
  always_ff @(posedge clk) begin
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      wbuf_q[i] <= wbuf_d[i];
    end
  end

endmodule

// File: tb/tb_spram_fifo_sched.sv
// Testbench for spram_fifo_sched: drives directed and random traffic, models
// the attached SPRAM, and compares every output each cycle against a
// queue-based reference of the scheduler's rules.
module tb_spram_fifo_sched;

  localparam int DW = 8;
  localparam int FD = 32;
  localparam int AW = 5;
  localparam int WB = 2;
  localparam int MS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wen, ren;
  logic [DW-1:0] wdata;
  logic          full, rack, rvalid, empty;
  logic [DW-1:0] rdata;
  logic [AW:0]   count;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  spram_fifo_sched #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .ADDR_WIDTH(AW),
    .WBUF_DEPTH(WB), .MAX_RD_STREAK(MS)
  ) dut (
    .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .full(full),
    .ren(ren), .rack(rack), .rdata(rdata), .rvalid(rvalid),
    .empty(empty), .count(count), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SPRAM macro: 1-cycle read latency
  logic [DW-1:0] ram [FD];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Reference model state
  logic [DW-1:0] wq[$];
  logic [DW-1:0] rq[$];
  int            wa, ra, streak;
  bit            prev_r;
  logic [DW-1:0] prev_d;
  bit            e_full, e_wg, e_rg, e_push, e_cw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    wq.delete();
    rq.delete();
    wa = 0; ra = 0; streak = 0;
    prev_r = 1'b0;
    prev_d = '0;
  endtask

  task automatic model_eval(input bit w, input bit r);
    bit cr;
    cr     = r && (rq.size() > 0);
    e_cw   = (wq.size() > 0);
    e_wg   = e_cw && (!cr || (wq.size() == WB) || (streak == MS));
    e_rg   = cr && !e_wg;
    e_full = (wq.size() == WB) || (rq.size() + wq.size() >= FD);
    e_push = w && !e_full;
  endtask

  task automatic model_step(input logic [DW-1:0] d);
    if (e_wg) begin
      rq.push_back(wq.pop_front());
      wa = (wa + 1) % FD;
    end
    prev_r = e_rg;
    if (e_rg) begin
      prev_d = rq.pop_front();
      ra = (ra + 1) % FD;
    end
    if (e_wg || !e_cw) streak = 0;
    else if (e_rg && streak < MS) streak++;
    if (e_push) wq.push_back(d);
  endtask

  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r);
    @(negedge clk);
    wen = w; wdata = d; ren = r;
    #1;
    model_eval(w, r);
    chk("full",      full,      e_full);
    chk("empty",     empty,     rq.size() == 0);
    chk("count",     count,     rq.size());
    chk("rack",      rack,      e_rg);
    chk("mem_en",    mem_en,    e_wg || e_rg);
    chk("mem_we",    mem_we,    e_wg);
    chk("mem_addr",  mem_addr,  e_wg ? wa : (e_rg ? ra : 0));
    chk("mem_wdata", mem_wdata, e_wg ? wq[0] : '0);
    chk("rvalid",    rvalid,    prev_r);
    chk("rdata",     rdata,     prev_r ? prev_d : '0);
    @(posedge clk);
    model_step(d);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (rq.size() > 0 || wq.size() > 0); k++)
      cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    chk("drain_count", count, 0);
    chk("drain_empty", empty, 1);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    wen = 1'b0; ren = 1'b1;
    #1;
    model_eval(1'b0, 1'b1);
    chk("rack_pre_rst", rack, e_rg);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full",  full,  0);
    chk("rst_rack",  rack,  0);
    chk("rst_mem_en", mem_en, 0);
    model_clear();
    @(negedge clk);
    rst = 1'b0; ren = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; ren = 1'b0; wdata = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state and basic write-then-read
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // Fill past capacity with no reads; extra writes must be refused
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'($urandom), 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("fill_count", count, FD);
    chk("fill_full",  full,  1);
    drain();

    // Read streak bound: 10 committed words, reads held, one write
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom), 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    chk("streak_count", count, 6);
    drain();

    // Continuous read and write pressure
    for (int i = 0; i < 60; i++) cycle(1'b1, 8'($urandom), 1'b1);
    drain();

    // Fill, empty, then write 5 more across the pointer wrap
    for (int i = 0; i < 36; i++) cycle(1'b1, 8'($urandom), 1'b0);
    drain();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0);
    drain();

    // Random traffic with shifting read/write bias
    for (int p = 0; p < 4; p++) begin
      int wp, rp;
      wp = 30 + 20 * p;
      rp = 90 - 20 * p;
      for (int i = 0; i < 400; i++)
        cycle($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp);
    end
    drain();

    // Reset while a read is being granted
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b0);
    reset_mid();
    cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 8'h5A, 1'b0);
    cycle(1'b0, '0, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
